// File: rtl/div_8bit_seq.sv
// ----------------------------------------------------------------------------
// div_8bit_seq
//   Iterative restoring divider. It produces one quotient bit per clock by
//   trial subtraction, so a nonzero-divisor operation needs WIDTH BUSY cycles.
//   A valid/ready handshake sits on the issue side and another on the result
//   side. A zero divisor skips the iterations and goes straight to DONE.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   in_valid     in   1      operands valid
//   in_ready     out  1      high only in IDLE
//   dividend     in   WIDTH  numerator, sampled on accept
//   divisor      in   WIDTH  denominator, sampled on accept
//   out_valid    out  1      high only in DONE
//   out_ready    in   1      consumer takes result
//   quotient     out  WIDTH  result quotient (held until next DONE entry)
//   remainder    out  WIDTH  result remainder (held until next DONE entry)
//   div_by_zero  out  1      last result came from a zero divisor
//
// Configuration
//   DIV_SIGNED_EN  when defined, operands are two's complement. The core
//                  divides magnitudes. Sign fix-up is combinational on the
//                  held results: the quotient is negated when the operand
//                  signs differ, and the remainder takes the dividend's sign.
// ----------------------------------------------------------------------------
module div_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // Iteration state
    logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
    logic [WIDTH-1:0] q_acc_q,   q_acc_d;
    logic [WIDTH-1:0] dvs_q,     dvs_d;
    logic [CW-1:0]    cnt_q,     cnt_d;

    // Held results (magnitudes when signed)
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q,  rmd_d;
    logic             dbz_q,  dbz_d;

    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One restoring step
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_q;

    assign accept = in_valid && in_ready;
    assign finish = (state_q == S_BUSY) && (cnt_q == '0);

    // Shift {rem_acc,q_acc} left by one. The top WIDTH+1 bits are the
    // partial remainder that is tried against the divisor.
    assign shifted = {rem_acc_q, q_acc_q[WIDTH-1]};

    // (WIDTH+1)-bit a + ~b + 1 subtractor.
    assign trial = shifted + ~{1'b0, dvs_q} + {{WIDTH{1'b0}}, 1'b1};

    // shifted can reach 2^(WIDTH+1)-1 while the divisor stays below 2^WIDTH.
    // When shifted's MSB is set, the difference is positive. Otherwise both
    // values fit in WIDTH bits, so trial's MSB is the sign.
    assign trial_ok = shifted[WIDTH] | ~trial[WIDTH];

    assign step_rem = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_q   = {q_acc_q[WIDTH-2:0], trial_ok};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = (divisor == '0) ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        rem_acc_d = rem_acc_q;
        q_acc_d   = q_acc_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;
        if (accept) begin
            if (divisor == '0) begin
                quot_d = '1;
                rmd_d  = dividend;
                dbz_d  = 1'b1;
            end else begin
                // The quotient bits shift into q_acc as the dividend shifts out.
                rem_acc_d = '0;
                q_acc_d   = a_mag;
                dvs_d     = b_mag;
                cnt_d     = CW'(WIDTH - 1);
                dbz_d     = 1'b0;
            end
        end else if (state_q == S_BUSY) begin
            rem_acc_d = step_rem;
            q_acc_d   = step_q;
            if (cnt_q == '0) begin
                quot_d = step_q;
                rmd_d  = step_rem;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_acc_q <= '0;
            q_acc_q   <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rmd_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            rem_acc_q <= rem_acc_d;
            q_acc_q   <= q_acc_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
        end
    end

    assign div_by_zero = dbz_q;

`ifdef DIV_SIGNED_EN
    // Signs of the operation in flight, and signs of the held result.
    // The held-result flags are updated only on DONE entry, so the outputs
    // stay stable while the next operation iterates.
    logic op_qneg_q,  op_qneg_d;
    logic op_rneg_q,  op_rneg_d;
    logic res_qneg_q, res_qneg_d;
    logic res_rneg_q, res_rneg_d;

    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    always_comb begin
        op_qneg_d  = op_qneg_q;
        op_rneg_d  = op_rneg_q;
        res_qneg_d = res_qneg_q;
        res_rneg_d = res_rneg_q;
        if (accept) begin
            if (divisor == '0) begin
                // A zero-divisor result is reported raw, with no fix-up.
                res_qneg_d = 1'b0;
                res_rneg_d = 1'b0;
            end else begin
                op_qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                op_rneg_d = dividend[WIDTH-1];
            end
        end else if (finish) begin
            res_qneg_d = op_qneg_q;
            res_rneg_d = op_rneg_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_qneg_q  <= 1'b0;
            op_rneg_q  <= 1'b0;
            res_qneg_q <= 1'b0;
            res_rneg_q <= 1'b0;
        end else begin
            op_qneg_q  <= op_qneg_d;
            op_rneg_q  <= op_rneg_d;
            res_qneg_q <= res_qneg_d;
            res_rneg_q <= res_rneg_d;
        end
    end

    // For most-negative / -1, the magnitude quotient is 2^(WIDTH-1) and is
    // not negated, so it already reads as the most-negative value.
    assign quotient  = res_qneg_q ? -quot_q : quot_q;
    assign remainder = res_rneg_q ? -rmd_q  : rmd_q;
`else
    assign a_mag     = dividend;
    assign b_mag     = divisor;
    assign quotient  = quot_q;
    assign remainder = rmd_q;
`endif

endmodule

// File: tb/tb_div_8bit_seq.sv
module tb_div_8bit_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, out_ready;
    logic [W-1:0] dividend, divisor;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_8bit_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    // Reference arithmetic: returns {div_by_zero, quotient, remainder}.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
`ifdef DIV_SIGNED_EN
        int sa, sb;
`endif
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sa == -(2 ** (W - 1)) && sb == -1) begin
            q = {1'b1, {(W-1){1'b0}}};
            r = '0;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
`else
        q = a / b;
        r = a % b;
`endif
        return {1'b0, q, r};
    endfunction

    logic [2*W:0] ref_v;
    assign ref_v = ref_div(dividend, divisor);

    // Behavioural model. Phase 0 is idle, phase 1 is computing, phase 2 holds a result.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_z = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_left <= 0;
            m_q <= '0; m_r <= '0; m_z <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    if (ref_v[2*W]) begin
                        {m_z, m_q, m_r} <= ref_v;
                        m_phase <= 2;
                    end else begin
                        m_z <= 1'b0;
                        {p_q, p_r} <= ref_v[2*W-1:0];
                        m_left <= W;
                        m_phase <= 1;
                    end
                end
                1: begin
                    if (m_left == 1) begin
                        m_phase <= 2; m_q <= p_q; m_r <= p_r;
                    end
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("in_ready",    W'(in_ready),    W'(m_phase == 0));
        chk("out_valid",   W'(out_valid),   W'(m_phase == 2));
        chk("quotient",    quotient,        m_q);
        chk("remainder",   remainder,       m_r);
        chk("div_by_zero", W'(div_by_zero), W'(m_z));
    end

    // Issue one operation, wait for its result, hold it for `hold` cycles, then retire it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit scribble,
                          output logic [W-1:0] gq, output logic [W-1:0] gr, output logic gz);
        int lat;
        in_valid = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #2;
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 30 && lat == 0; n++) begin
            @(negedge clk);
            if (out_valid) lat = n;
            else if (scribble) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = W'($urandom); divisor = W'($urandom);
            end
        end
        if (lat == 0) chk("result_timeout", W'(out_valid), W'(1));
        chk("latency", W'(lat), (b == '0) ? W'(1) : W'(W + 1));
        gq = quotient; gr = remainder; gz = div_by_zero;
        for (int h = 0; h < hold; h++) begin
            if (scribble) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = W'($urandom); divisor = W'($urandom);
            end
            @(negedge clk);
        end
        if (hold > 0) chk("hold_in_ready", W'(in_ready), W'(0));
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

`ifdef DIV_SIGNED_EN
    localparam logic [W-1:0] A1 = 8'h9C, B1 = 8'h07, Q1 = 8'hF2, R1 = 8'hFE;
`else
    localparam logic [W-1:0] A1 = 8'd200, B1 = 8'd7, Q1 = 8'd28, R1 = 8'd4;
`endif

    initial begin
        logic [W-1:0] gq, gr, ra, rb;
        logic         gz;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;

        @(negedge clk);
        chk("rst_in_ready",  W'(in_ready),    W'(1));
        chk("rst_out_valid", W'(out_valid),   W'(0));
        chk("rst_quotient",  quotient,        W'(0));
        chk("rst_remainder", remainder,       W'(0));
        chk("rst_dbz",       W'(div_by_zero), W'(0));
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;

        run_op(A1, B1, 0, 0, gq, gr, gz);
        chk("t1_q", gq, Q1); chk("t1_r", gr, R1); chk("t1_z", W'(gz), W'(0));

        run_op(8'd7, 8'd9, 0, 0, gq, gr, gz);
        chk("t3a_q", gq, W'(0)); chk("t3a_r", gr, W'(7));
        run_op(8'd255, 8'd1, 0, 0, gq, gr, gz);
        chk("t3b_q", gq, W'(8'hFF)); chk("t3b_r", gr, W'(0));

        run_op(A1, B1, 5, 0, gq, gr, gz);
        chk("t4_q", quotient, Q1); chk("t4_r", remainder, R1);
        @(negedge clk);
        chk("t4_idle_in_ready",  W'(in_ready),  W'(1));
        chk("t4_idle_out_valid", W'(out_valid), W'(0));
        @(posedge clk); #2;

        run_op(8'd5, 8'd0, 1, 0, gq, gr, gz);
        chk("t2_q", gq, W'(8'hFF)); chk("t2_r", gr, W'(5)); chk("t2_z", W'(gz), W'(1));

        // Reset after four BUSY edges discards the operation.
        in_valid = 1'b1; dividend = A1; divisor = B1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t5_in_ready",  W'(in_ready),    W'(1));
        chk("t5_out_valid", W'(out_valid),   W'(0));
        chk("t5_quotient",  quotient,        W'(0));
        chk("t5_remainder", remainder,       W'(0));
        chk("t5_dbz",       W'(div_by_zero), W'(0));
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        run_op(8'd100, 8'd10, 0, 0, gq, gr, gz);
        chk("t5b_q", gq, W'(10)); chk("t5b_r", gr, W'(0));

`ifdef DIV_SIGNED_EN
        run_op(8'h80, 8'hFF, 0, 0, gq, gr, gz);
        chk("t6_ovf_q", gq, W'(8'h80)); chk("t6_ovf_r", gr, W'(0)); chk("t6_ovf_z", W'(gz), W'(0));
        run_op(8'h80, 8'h01, 0, 0, gq, gr, gz);
        chk("t6_min_q", gq, W'(8'h80)); chk("t6_min_r", gr, W'(0));
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)), 1, gq, gr, gz);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
